// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: rebuilds 4 channel words from a slot stream
// and presents each complete frame with a one-cycle y_valid pulse.
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           sync,
  input  logic [W-1:0]   din,
  output logic [4*W-1:0] y,
  output logic           y_valid,
  output logic [1:0]     slot,
  output logic           locked,
  output logic           err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q;
  logic [1:0]     slot_q;
  logic [W-1:0]   shadow_q [3];
  logic [4*W-1:0] y_q;
  logic           y_valid_q;
  logic           err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      slot_q    <= 2'd0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      // Pulses default low; only the cycle after a slot event raises them.
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && sync) begin
            shadow_q[0] <= din;
            slot_q      <= 2'd1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (sync && (slot_q != 2'd0)) begin
              // Misaligned marker: drop the partial frame and restart at slot 0.
              err_q       <= 1'b1;
              shadow_q[0] <= din;
              slot_q      <= 2'd1;
            end else if (slot_q == 2'd3) begin
              y_q       <= {din, shadow_q[2], shadow_q[1], shadow_q[0]};
              y_valid_q <= 1'b1;
              slot_q    <= 2'd0;
            end else begin
              for (int i = 0; i < 3; i++) begin
                if (slot_q == 2'(i)) begin
                  shadow_q[i] <= din;
                end
              end
              slot_q <= slot_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign slot    = slot_q;
  assign locked  = (state_q == RUN);
  assign err     = err_q;

endmodule
